// File: rtl/cfg_loader_pkg.sv
// Shared constants and state type for the config-register loader and the
// config register file decode.
package cfg_loader_pkg;

  // Config register file geometry.
  localparam int unsigned CFG_REG_NUM = 16;
  localparam int unsigned CFG_IDX_W   = 4;

  // Load length counter must hold 0..31 so out-of-range requests are visible.
  localparam int unsigned CFG_CNT_W   = 5;
  localparam int unsigned CFG_DATA_W  = 8;

  // Pacing counter width (GAP is 0..15).
  localparam int unsigned CFG_GAP_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    STROBE,
    PACE,
    DONE
  } cfg_ld_state_t;

  // A load length is legal when it covers at least one and at most all
  // registers of the file.
  function automatic logic cfg_count_ok(input logic [CFG_CNT_W-1:0] cnt);
    return (cnt != '0) && (cnt <= CFG_CNT_W'(CFG_REG_NUM));
  endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// Byte-stream input and config-window write port of the loader.
// master: the loader (consumes the stream, drives the write strobes).
// slave:  the environment (stream source, config register file side).
interface cfg_loader_if;
  import cfg_loader_pkg::*;

  // Stream side
  logic                  s_valid;
  logic [CFG_DATA_W-1:0] s_data;
  logic                  s_ready;

  // Config write window side
  logic                  wr_act;
  logic                  wr_we;
  logic                  wr_ce_cfg;
  logic [CFG_IDX_W-1:0]  wr_addr;
  logic [CFG_DATA_W-1:0] wr_dato;

  modport master (
    input  s_valid,
    input  s_data,
    output s_ready,
    output wr_act,
    output wr_we,
    output wr_ce_cfg,
    output wr_addr,
    output wr_dato
  );

  modport slave (
    output s_valid,
    output s_data,
    input  s_ready,
    input  wr_act,
    input  wr_we,
    input  wr_ce_cfg,
    input  wr_addr,
    input  wr_dato
  );

endinterface

// File: rtl/cfg_loader.sv
// Config-register loader: drains a byte stream and replays it as paced
// single-cycle write strobes into consecutive config register indices.
// All outputs are flops; the control outputs are registered copies of the
// next-state decode so they line up with the state register.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CFG_IDX_W-1:0] base,
  input  logic [CFG_CNT_W-1:0] count,
  cfg_loader_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam bit                   HAS_GAP  = (GAP != 0);
  // Pacing counter is preloaded with GAP-1 and runs down to zero.
  localparam logic [CFG_GAP_W-1:0] GAP_LAST = HAS_GAP ? CFG_GAP_W'(GAP - 1) : '0;

  cfg_ld_state_t        state;
  cfg_ld_state_t        state_nx;
  logic [CFG_IDX_W-1:0] idx;
  logic [CFG_CNT_W-1:0] remaining;
  logic [CFG_GAP_W-1:0] gap_cnt;

  logic                 load_ok;
  logic                 load_bad;
  logic                 accept;
  logic                 advance;

  assign load_ok  = (state == IDLE) && start &&  cfg_count_ok(count);
  assign load_bad = (state == IDLE) && start && !cfg_count_ok(count);
  // Handshake: s_ready is high exactly while in WAIT_DATA.
  assign accept   = (state == WAIT_DATA) && bus.s_valid;
  // Next-step decision point: end of STROBE without pacing, or end of PACE.
  assign advance  = ((state == STROBE) && !HAS_GAP) ||
                    ((state == PACE) && (gap_cnt == '0));

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (load_ok) state_nx = WAIT_DATA;
      WAIT_DATA: if (bus.s_valid) state_nx = STROBE;
      STROBE: begin
        if (HAS_GAP)               state_nx = PACE;
        else if (remaining == '0)  state_nx = DONE;
        else                       state_nx = WAIT_DATA;
      end
      PACE: begin
        if (gap_cnt == '0) state_nx = (remaining == '0) ? DONE : WAIT_DATA;
      end
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // State register, registered control outputs and the load datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      remaining     <= '0;
      gap_cnt       <= '0;
      bus.s_ready   <= 1'b0;
      bus.wr_act    <= 1'b0;
      bus.wr_we     <= 1'b0;
      bus.wr_ce_cfg <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_dato   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.s_ready   <= (state_nx == WAIT_DATA);
      bus.wr_act    <= (state_nx == STROBE);
      bus.wr_we     <= (state_nx == STROBE);
      bus.wr_ce_cfg <= (state_nx == STROBE);
      busy          <= (state_nx != IDLE);
      done          <= (state_nx == DONE);
      err           <= load_bad && !abort;

      // Abort freezes the datapath: nothing is latched, the held write
      // address/data stay as they were.
      if (!abort) begin
        if (load_ok) begin
          idx       <= base;
          remaining <= count;
        end

        if (accept) begin
          bus.wr_addr <= idx;
          bus.wr_dato <= bus.s_data;
          remaining   <= remaining - CFG_CNT_W'(1);
        end

        if (state == STROBE) begin
          gap_cnt <= GAP_LAST;
        end else if ((state == PACE) && (gap_cnt != '0)) begin
          gap_cnt <= gap_cnt - CFG_GAP_W'(1);
        end

        // Index only moves on when another byte is still owed; it wraps
        // naturally at the register file size.
        if (advance && (remaining != '0)) begin
          idx <= idx + CFG_IDX_W'(1);
        end
      end
    end
  end

  // Structural invariants of the strobe/handshake/done outputs.
  a_strobe_not_ready: assert property (@(posedge clk) disable iff (rst)
    bus.wr_act |-> !bus.s_ready);
  a_strobe_not_done: assert property (@(posedge clk) disable iff (rst)
    bus.wr_act |-> !done);
  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    !busy |-> (!bus.wr_act && !bus.s_ready && !done));
  a_qualifiers: assert property (@(posedge clk)
    (bus.wr_we == bus.wr_act) && (bus.wr_ce_cfg == bus.wr_act));

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: two instances (GAP=1 and GAP=0), a timing-rule model
// of the expected outputs, a per-cycle compare process and literal checks of
// the write sequences seen on each instance.
module tb_cfg_loader;
  import cfg_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus, index 0 -> GAP=1 instance, index 1 -> GAP=0 instance
  logic [1:0] st;
  logic [1:0] ab;
  logic [1:0] sv;
  logic [3:0] bs [2];
  logic [4:0] cn [2];
  logic [7:0] sd [2];
  bit   [1:0] en;

  // Observed outputs
  logic [1:0] busy_o, done_o, err_o, ready_o, act_o, we_o, ce_o;
  logic [3:0] addr_o [2];
  logic [7:0] dato_o [2];

  cfg_loader_if bus_g1 ();
  cfg_loader_if bus_g0 ();

  assign bus_g1.s_valid = sv[0];
  assign bus_g1.s_data  = sd[0];
  assign bus_g0.s_valid = sv[1];
  assign bus_g0.s_data  = sd[1];

  assign ready_o[0] = bus_g1.s_ready;
  assign act_o[0]   = bus_g1.wr_act;
  assign we_o[0]    = bus_g1.wr_we;
  assign ce_o[0]    = bus_g1.wr_ce_cfg;
  assign addr_o[0]  = bus_g1.wr_addr;
  assign dato_o[0]  = bus_g1.wr_dato;
  assign ready_o[1] = bus_g0.s_ready;
  assign act_o[1]   = bus_g0.wr_act;
  assign we_o[1]    = bus_g0.wr_we;
  assign ce_o[1]    = bus_g0.wr_ce_cfg;
  assign addr_o[1]  = bus_g0.wr_addr;
  assign dato_o[1]  = bus_g0.wr_dato;

  cfg_loader #(.GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]),
    .base(bs[0]), .count(cn[0]), .bus(bus_g1),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  cfg_loader #(.GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]),
    .base(bs[1]), .count(cn[1]), .bus(bus_g0),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int gapv [2] = '{1, 0};

  // Stream sources
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  // Model: event times derived from the timing rules
  int m_active [2], m_accept [2], m_ready_from [2];
  int m_strobe_at [2], m_done_at [2], m_err_at [2];
  int m_rem [2], m_idx [2], m_addr [2], m_dato [2];

  // Literal expectations (written by stimulus only)
  int lit_addr [16];
  int lit_data [16];
  int lit_d, lit_n, lit_space, lit_done, lit_err;
  bit lit_chk = 1'b0;

  // Observation log (written by compare process only)
  int obs_n [2], obs_done_n [2], obs_done_cyc [2], obs_err [2];
  int obs_cyc [2][16], obs_addr [2][16], obs_data [2][16];
  bit lit_seen = 1'b0;

  function automatic void chk(string name, int d, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %0d, want %0d", name, d, cyc, act, exp);
    end
  endfunction

  function automatic void refresh_src();
    sv[0] = en[0] && (q0.size() > 0);
    sd[0] = (q0.size() > 0) ? q0[0] : 8'h00;
    sv[1] = en[1] && (q1.size() > 0);
    sd[1] = (q1.size() > 0) ? q1[0] : 8'h00;
  endfunction

  function automatic void push(int d, logic [7:0] b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
    refresh_src();
  endfunction

  function automatic void flush_src();
    q0.delete();
    q1.delete();
    refresh_src();
  endfunction

  // Advance the model from cycle cyc to cyc+1 given this cycle's inputs.
  function automatic void model_step(int d);
    int c;
    c = cyc;
    if (rst) begin
      m_active[d] = 0; m_accept[d] = 0; m_ready_from[d] = 0;
      m_strobe_at[d] = -1; m_done_at[d] = -1; m_err_at[d] = -1;
      m_rem[d] = 0; m_idx[d] = 0; m_addr[d] = 0; m_dato[d] = 0;
    end else if (ab[d]) begin
      m_active[d] = 0; m_accept[d] = 0;
      m_strobe_at[d] = -1; m_done_at[d] = -1;
    end else if (m_active[d] == 0) begin
      if (st[d]) begin
        if (int'(cn[d]) >= 1 && int'(cn[d]) <= CFG_REG_NUM) begin
          m_active[d] = 1; m_accept[d] = 1; m_ready_from[d] = c + 1;
          m_rem[d] = int'(cn[d]); m_idx[d] = int'(bs[d]);
        end else begin
          m_err_at[d] = c + 1;
        end
      end
    end else begin
      if (m_accept[d] != 0 && c >= m_ready_from[d] && sv[d]) begin
        m_addr[d] = m_idx[d];
        m_dato[d] = int'(sd[d]);
        m_rem[d]--;
        m_strobe_at[d] = c + 1;
        m_accept[d] = 0;
        if (m_rem[d] > 0) begin
          m_idx[d] = (m_idx[d] + 1) % CFG_REG_NUM;
          m_accept[d] = 1;
          m_ready_from[d] = c + 2 + gapv[d];
        end else begin
          m_done_at[d] = c + 2 + gapv[d];
        end
      end
      if (c == m_done_at[d]) m_active[d] = 0;
    end
  endfunction

  task automatic tick();
    logic [1:0] hs;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d);
    hs = sv & ready_o;
    @(posedge clk);
    #1;
    cyc++;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    refresh_src();
  endtask

  task automatic pulse_start(int d, logic [3:0] b, logic [4:0] c);
    bs[d] = b;
    cn[d] = c;
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
  endtask

  task automatic lit(int d, int n, int space, int done_dly, int e);
    lit_d = d; lit_n = n; lit_space = space; lit_done = done_dly; lit_err = e;
    lit_chk = ~lit_chk;
    tick();
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          int es;
          es = (m_strobe_at[d] == cyc) ? 1 : 0;
          chk("wr_act",    d, int'(act_o[d]),  es);
          chk("wr_we",     d, int'(we_o[d]),   es);
          chk("wr_ce_cfg", d, int'(ce_o[d]),   es);
          chk("s_ready",   d, int'(ready_o[d]),
              (m_active[d] != 0 && m_accept[d] != 0 && cyc >= m_ready_from[d]) ? 1 : 0);
          chk("busy",      d, int'(busy_o[d]), m_active[d]);
          chk("done",      d, int'(done_o[d]), (m_done_at[d] == cyc) ? 1 : 0);
          chk("err",       d, int'(err_o[d]),  (m_err_at[d] == cyc) ? 1 : 0);
          chk("wr_addr",   d, int'(addr_o[d]), m_addr[d]);
          chk("wr_dato",   d, int'(dato_o[d]), m_dato[d]);

          if (act_o[d] && obs_n[d] < 16) begin
            obs_cyc[d][obs_n[d]]  = cyc;
            obs_addr[d][obs_n[d]] = int'(addr_o[d]);
            obs_data[d][obs_n[d]] = int'(dato_o[d]);
            obs_n[d]++;
          end
          if (done_o[d]) begin
            obs_done_n[d]++;
            obs_done_cyc[d] = cyc;
          end
          if (err_o[d]) obs_err[d]++;
        end
      end

      if (lit_chk != lit_seen) begin
        lit_seen = lit_chk;
        chk("lit_count", lit_d, obs_n[lit_d], lit_n);
        for (int i = 0; i < lit_n && i < obs_n[lit_d]; i++) begin
          chk("lit_addr", lit_d, obs_addr[lit_d][i], lit_addr[i]);
          chk("lit_data", lit_d, obs_data[lit_d][i], lit_data[i]);
          if (i > 0) chk("lit_space", lit_d, obs_cyc[lit_d][i] - obs_cyc[lit_d][i-1], lit_space);
        end
        if (lit_done < 0) begin
          chk("lit_no_done", lit_d, obs_done_n[lit_d], 0);
        end else begin
          chk("lit_done_n", lit_d, obs_done_n[lit_d], 1);
          if (obs_n[lit_d] > 0)
            chk("lit_done_dly", lit_d, obs_done_cyc[lit_d] - obs_cyc[lit_d][obs_n[lit_d]-1], lit_done);
        end
        chk("lit_err", lit_d, obs_err[lit_d], lit_err);
        for (int d = 0; d < 2; d++) begin
          obs_n[d] = 0; obs_done_n[d] = 0; obs_done_cyc[d] = -1; obs_err[d] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; st = '0; ab = '0; en = '0; sv = '0;
    for (int d = 0; d < 2; d++) begin
      bs[d] = '0; cn[d] = '0; sd[d] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Reset state: nothing happened
    lit(0, 0, 0, -1, 0);

    // Basic load, GAP=1: addr 0,1,2 / A1,B2,C3, 3 cycles apart, done 2 after
    en = 2'b11;
    push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3);
    pulse_start(0, 4'd0, 5'd3);
    repeat (13) tick();
    lit_addr[0] = 0;  lit_data[0] = 'hA1;
    lit_addr[1] = 1;  lit_data[1] = 'hB2;
    lit_addr[2] = 2;  lit_data[2] = 'hC3;
    lit(0, 3, 3, 2, 0);

    // Wrap: base 15, two writes -> (15,11) then (0,22)
    push(0, 8'h11); push(0, 8'h22);
    pulse_start(0, 4'd15, 5'd2);
    repeat (10) tick();
    lit_addr[0] = 15; lit_data[0] = 'h11;
    lit_addr[1] = 0;  lit_data[1] = 'h22;
    lit(0, 2, 3, 2, 0);

    // Backpressure: second byte offered 5 cycles after s_ready returns
    push(0, 8'h5A);
    pulse_start(0, 4'd3, 5'd2);
    repeat (8) tick();
    push(0, 8'h6B);
    repeat (6) tick();
    lit_addr[0] = 3;  lit_data[0] = 'h5A;
    lit_addr[1] = 4;  lit_data[1] = 'h6B;
    lit(0, 2, 8, 2, 0);

    // Rejects: count 0, then count 17
    pulse_start(0, 4'd2, 5'd0);
    repeat (2) tick();
    lit(0, 0, 0, -1, 1);
    pulse_start(0, 4'd3, 5'd17);
    repeat (2) tick();
    lit(0, 0, 0, -1, 1);

    // Start while busy is ignored
    push(0, 8'h77);
    pulse_start(0, 4'd8, 5'd1);
    tick();
    pulse_start(0, 4'd2, 5'd3);
    repeat (5) tick();
    lit_addr[0] = 8;  lit_data[0] = 'h77;
    lit(0, 1, 0, 2, 0);

    // Abort in PACE after the first of four writes
    push(0, 8'h10); push(0, 8'h20); push(0, 8'h30); push(0, 8'h40);
    pulse_start(0, 4'd4, 5'd4);
    repeat (2) tick();
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    repeat (6) tick();
    flush_src();
    lit_addr[0] = 4;  lit_data[0] = 'h10;
    lit(0, 1, 0, -1, 0);

    // Abort and start together: nothing latched
    push(0, 8'h55);
    ab[0] = 1'b1;
    pulse_start(0, 4'd1, 5'd2);
    ab[0] = 1'b0;
    repeat (4) tick();
    flush_src();
    lit(0, 0, 0, -1, 0);

    // Reset on the handshake cycle: no strobe afterwards
    push(0, 8'h99); push(0, 8'hAA);
    pulse_start(0, 4'd6, 5'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    flush_src();
    lit(0, 0, 0, -1, 0);

    // Full sweep on the GAP=0 instance: base 5, 16 writes, 2 cycles apart
    for (int i = 0; i < 16; i++) begin
      push(1, 8'(8'h80 + i));
      lit_addr[i] = (5 + i) % 16;
      lit_data[i] = 'h80 + i;
    end
    pulse_start(1, 4'd5, 5'd16);
    repeat (35) tick();
    lit(1, 16, 2, 1, 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Initiator for the config-register write window: drains a byte stream (valid/ready) and replays it as paced single-cycle write strobes into the 16-entry system config register file. It sits beside the PI bus decode and lets on-chip sources (menu/save-state key handlers, boot defaults) load a contiguous slice of config without MCU involvement. Its write outputs are OR-merged with PI write qualifiers upstream of the config register file.

## Interface
- `GAP`, default 1: idle cycles inserted after each write strobe (0..15).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `abort`  in  1  cancel the load; takes priority over everything.
- `base`  in  4  first register index, sampled with `start`.
- `count`  in  5  number of registers to write (1..16), sampled with `start`.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `wr_act`  out  1  one-cycle write strobe (act_sync equivalent).
- `wr_we`  out  1  write qualifier; equal to `wr_act`.
- `wr_ce_cfg`  out  1  config-window select; equal to `wr_act`.
- `wr_addr`  out  4  register index.
- `wr_dato`  out  8  write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last write completes.
- `err`  out  1  one-cycle pulse on a rejected `start`.

## Operation
- States: IDLE, WAIT_DATA, STROBE, PACE, DONE.
- IDLE: if `start` and 1 <= `count` <= 16, latch `base` into the index register, latch `count` into the remaining counter, then go to WAIT_DATA. If `start` with `count` 0 or 17..31, pulse `err` next cycle and stay in IDLE.
- WAIT_DATA: `s_ready`=1. On `s_valid & s_ready`:
  - load `wr_dato`<=`s_data` and `wr_addr`<=index;
  - decrement remaining;
  - go to STROBE.
- STROBE (exactly 1 cycle): `wr_act`=`wr_we`=`wr_ce_cfg`=1. Then go to PACE if `GAP`>0, else to the next-step decision below.
- PACE: count `GAP` cycles, then take the next-step decision.
- Next-step decision: remaining==0 goes to DONE; otherwise index<=index+1 (mod 16) and go to WAIT_DATA.
- DONE: `done`=1 for one cycle, then IDLE.
- Index wrap: `base`=14, `count`=4 writes 14, 15, 0, 1.
- `wr_addr` and `wr_dato` are held stable from the STROBE cycle until the next byte is accepted. Both are retained in IDLE.
- `start` while `busy` is ignored; no `err` is raised.
- `abort` (any state): next state is IDLE and `s_ready` drops next cycle. No further strobes, no `done`.
  - A strobe already showing in the current STROBE cycle is not retracted.
  - `abort`+`start` in the same IDLE cycle: abort wins and nothing is latched.
- `s_data` is accepted only on handshake; bytes not consumed remain upstream.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset values: state IDLE; `s_ready`, `wr_act`, `wr_we`, `wr_ce_cfg`, `busy`, `done`, `err` = 0; `wr_addr`=0; `wr_dato`=0; remaining counter 0.
- `start` at cycle 0: `busy`=1 and `s_ready`=1 at cycle 1.
- Handshake at cycle k: strobe at cycle k+1.
- Next `s_ready` at cycle k+2+`GAP` (when remaining > 0).
- Continuous stream, `GAP`=1: one write per 3 cycles.
- For N writes, the last strobe is at cycle s; `done` is at cycle s+1+`GAP`; `busy` is 0 at cycle s+2+`GAP`.
- Reset mid-operation: immediate return to IDLE. No strobe or `done` appears in the cycle after `rst`.

## Structure
- Shared package holds:
  - `CFG_REG_NUM`=16 and `CFG_IDX_W`=4;
  - the state enum `cfg_ld_state_t`.
- These constants are shared with the config register file decode.
- Single module. The `GAP` pacing counter is inline; no sub-module is needed.

## Test plan
- Basic load: reset, then `start`, `base`=0, `count`=3, stream 0xA1, 0xB2, 0xC3 with `s_valid` held, `GAP`=1 -> strobes at addr 0, 1, 2 with matching data, 3 cycles apart; `done` 2 cycles after the last strobe.
- Wrap: `base`=15, `count`=2, bytes 0x11, 0x22 -> writes (15, 0x11) then (0, 0x22).
- Backpressure: `s_valid` low for 5 cycles between bytes -> `s_ready` held high; no strobe until the handshake; strobe 1 cycle after it.
- Rejects: `count`=0 -> `err` pulse, `busy` stays 0. `count`=17 -> `err`. A second `start` while busy -> no effect and no `err`.
- Abort: abort in PACE after the first of 4 writes -> IDLE next cycle, exactly 1 strobe total, no `done`. Abort+start in the same cycle -> `busy` stays 0.
- Full sweep with `GAP`=0: `base`=5, `count`=16 -> 16 strobes covering every index once, one write per 2 cycles; `done` follows.
